// File: rtl/io_sequence_checker.sv
// io_sequence_checker
//
// Watches a synchronous IO bus and checks that it walks through a programmed
// table of expected values. The bus is registered once (sample_q) before any
// comparison. A check is armed by a start pulse and ends in PASS once every
// entry has been seen in order, or in FAIL on an unexpected value (strict
// mode) or on a timeout (optional).
//
// Optional feature macro: SEQ_CHECKER_TIMEOUT_EN
//   When defined, adds the timeout_limit port and an idle-cycle counter.
//   When undefined, both are absent and fail_code 2'b10 is never produced.
//
// Ports
//   wb_clk_i       in   1        clock, rising edge
//   wb_rst_i       in   1        asynchronous active-high reset
//   sample_in      in   WIDTH    monitored bus
//   cfg_we         in   1        table write strobe (ignored while busy)
//   cfg_addr       in   AW       table write index
//   cfg_data       in   WIDTH    table write value
//   cfg_len        in   AW+1     entries to match, captured on start
//   strict         in   1        0 = ordered wait, 1 = strict; captured on start
//   start          in   1        arm pulse (ignored while busy)
//   timeout_limit  in   TW       idle-cycle limit, 0 disables (macro only)
//   busy           out  1        check armed
//   pass           out  1        sticky pass
//   fail           out  1        sticky fail
//   match_idx      out  AW+1     entries matched so far
//   fail_code      out  2        00 none, 01 unexpected value, 10 timeout
//   dbg_state      out  2        current FSM state for observation
//
// Strobe semantics: start and cfg_we are single-cycle strobes with no ready
// return. Both are accepted only while the FSM is outside WAIT; while a check
// is armed they are silently dropped.
module io_sequence_checker #(
    parameter int  WIDTH = 8,
    parameter int  DEPTH = 16,
    parameter int  TW    = 20,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_i,
    input  logic [WIDTH-1:0] sample_in,
    input  logic             cfg_we,
    input  logic [AW-1:0]    cfg_addr,
    input  logic [WIDTH-1:0] cfg_data,
    input  logic [AW:0]      cfg_len,
    input  logic             strict,
    input  logic             start,
`ifdef SEQ_CHECKER_TIMEOUT_EN
    input  logic [TW-1:0]    timeout_limit,
`endif
    output logic             busy,
    output logic             pass,
    output logic             fail,
    output logic [AW:0]      match_idx,
    output logic [1:0]       fail_code,
    output logic [1:0]       dbg_state
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_PASS = 2'd2,
        ST_FAIL = 2'd3
    } state_t;

    localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

    state_t           r_state, w_state_nxt;
    logic [WIDTH-1:0] r_table [DEPTH];
    logic [WIDTH-1:0] r_sample;
    logic [AW:0]      r_idx, w_idx_nxt;
    logic [AW:0]      r_len, w_len_nxt;
    logic             r_strict, w_strict_nxt;
    logic [1:0]       r_fail_code, w_fail_code_nxt;
    logic [AW:0]      w_start_len;
    logic [AW:0]      w_idx_inc;
    logic [AW-1:0]    w_cur_ptr;
    logic [AW-1:0]    w_prev_ptr;
    logic             w_hit;
    logic             w_hold;
`ifdef SEQ_CHECKER_TIMEOUT_EN
    logic [TW-1:0]    r_tmo, w_tmo_nxt;
    logic [TW:0]      w_tmo_inc;
    logic             w_tmo_expired;
`endif

    // Input register: every comparison sees the bus one cycle late.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_sample <= '0;
        end else begin
            r_sample <= sample_in;
        end
    end

    // Expected-value table; deliberately not reset so a check can be
    // replayed after a reset without reprogramming.
    always_ff @(posedge wb_clk_i) begin
        if (cfg_we && (r_state != ST_WAIT) && ({1'b0, cfg_addr} < DEPTH_L)) begin
            r_table[cfg_addr] <= cfg_data;
        end
    end

    assign w_start_len = (cfg_len > DEPTH_L) ? DEPTH_L : cfg_len;
    assign w_idx_inc   = r_idx + (AW+1)'(1);
    assign w_cur_ptr   = r_idx[AW-1:0];
    assign w_prev_ptr  = w_cur_ptr - AW'(1);
    assign w_hit       = (r_sample == r_table[w_cur_ptr]);
    // A repeat of the entry just consumed is tolerated in strict mode.
    assign w_hold      = (r_idx != '0) && (r_sample == r_table[w_prev_ptr]);

`ifdef SEQ_CHECKER_TIMEOUT_EN
    // Compare the value the counter would take this edge, so FAIL lands
    // exactly timeout_limit edges after the last match.
    assign w_tmo_inc     = {1'b0, r_tmo} + (TW+1)'(1);
    assign w_tmo_expired = (timeout_limit != '0) && (w_tmo_inc >= {1'b0, timeout_limit});
`endif

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_state     <= ST_IDLE;
            r_idx       <= '0;
            r_len       <= '0;
            r_strict    <= 1'b0;
            r_fail_code <= 2'b00;
`ifdef SEQ_CHECKER_TIMEOUT_EN
            r_tmo       <= '0;
`endif
        end else begin
            r_state     <= w_state_nxt;
            r_idx       <= w_idx_nxt;
            r_len       <= w_len_nxt;
            r_strict    <= w_strict_nxt;
            r_fail_code <= w_fail_code_nxt;
`ifdef SEQ_CHECKER_TIMEOUT_EN
            r_tmo       <= w_tmo_nxt;
`endif
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_idx_nxt       = r_idx;
        w_len_nxt       = r_len;
        w_strict_nxt    = r_strict;
        w_fail_code_nxt = r_fail_code;
`ifdef SEQ_CHECKER_TIMEOUT_EN
        w_tmo_nxt       = r_tmo;
`endif
        case (r_state)
            ST_WAIT: begin
                // Match wins over both the strict check and the timeout.
                if (w_hit) begin
                    w_idx_nxt = w_idx_inc;
`ifdef SEQ_CHECKER_TIMEOUT_EN
                    w_tmo_nxt = '0;
`endif
                    if (w_idx_inc == r_len) begin
                        w_state_nxt = ST_PASS;
                    end
                end else if (r_strict && (r_idx != '0) && !w_hold) begin
                    w_state_nxt     = ST_FAIL;
                    w_fail_code_nxt = 2'b01;
`ifdef SEQ_CHECKER_TIMEOUT_EN
                end else if (w_tmo_expired) begin
                    w_state_nxt     = ST_FAIL;
                    w_fail_code_nxt = 2'b10;
                end else begin
                    w_tmo_nxt = w_tmo_inc[TW-1:0];
`endif
                end
            end
            default: begin
                if (start) begin
                    w_idx_nxt       = '0;
                    w_len_nxt       = w_start_len;
                    w_strict_nxt    = strict;
                    w_fail_code_nxt = 2'b00;
`ifdef SEQ_CHECKER_TIMEOUT_EN
                    w_tmo_nxt       = '0;
`endif
                    w_state_nxt     = (w_start_len == '0) ? ST_PASS : ST_WAIT;
                end
            end
        endcase
    end

    assign busy      = (r_state == ST_WAIT);
    assign pass      = (r_state == ST_PASS);
    assign fail      = (r_state == ST_FAIL);
    assign match_idx = r_idx;
    assign fail_code = r_fail_code;
    assign dbg_state = r_state;

endmodule
